// File: rtl/mode_counter.sv
// mode_counter: programmable-period up/down counter with one-shot mode,
// mid-period tick and a saturating wrap counter.
module mode_counter #(
   parameter int CNT_W      = 16,
   parameter int WRAP_W     = 8,
   parameter int PERIOD_RST = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              start,
   input  logic              load,
   input  logic [CNT_W-1:0]  load_val,
   input  logic [CNT_W-1:0]  period,
   input  logic              dir,
   input  logic              one_shot,
   output logic [CNT_W-1:0]  cnt,
   output logic              cnt_end,
   output logic              cnt_mid,
   output logic              busy,
   output logic [WRAP_W-1:0] wrap_cnt
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0]  ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  PRST = CNT_W'(PERIOD_RST);
   localparam logic [WRAP_W-1:0] WMAX = '1;

   state_t state, state_d;

   logic [CNT_W-1:0]  cnt_d;
   logic [CNT_W-1:0]  p_lat, p_lat_d;
   logic [CNT_W-1:0]  p_new, p_top;
   logic [CNT_W-1:0]  s_val, t_val, m_val;
   logic [CNT_W-1:0]  s_new, lv_clip;
   logic [WRAP_W-1:0] wrap_d;
   logic              active, step, start_ok;

   // Derived values from the latched period and the current direction
   always_comb begin
      p_new   = (period == '0) ? ONE : period;
      p_top   = p_lat - ONE;
      s_val   = dir ? p_top : '0;
      t_val   = dir ? '0 : p_top;
      m_val   = dir ? (p_top - (p_lat >> 1)) : (p_lat >> 1);
      s_new   = dir ? (p_new - ONE) : '0;
      lv_clip = (load_val <= p_top) ? load_val : p_top;
   end

   // Tick outputs and next-state logic, priority clr > load > start > step
   always_comb begin
      active   = (state == RUN) || !one_shot;
      busy     = active;
      step     = en && active && !clr && !load;
      cnt_end  = step && (cnt == t_val);
      cnt_mid  = step && (cnt == m_val);
      start_ok = start && one_shot && (state == IDLE) && !clr && !load;
      state_d  = state;
      cnt_d    = cnt;
      p_lat_d  = p_lat;
      wrap_d   = wrap_cnt;
      if (clr) begin
         cnt_d   = s_val;
         p_lat_d = p_new;
         wrap_d  = '0;
         state_d = IDLE;
      end else if (load) begin
         cnt_d = lv_clip;
      end else if (start_ok) begin
         cnt_d   = s_new;
         p_lat_d = p_new;
         state_d = RUN;
      end else if (step) begin
         if (cnt_end) begin
            cnt_d   = s_val;
            p_lat_d = p_new;
            state_d = IDLE;
            if (wrap_cnt != WMAX)
               wrap_d = wrap_cnt + WRAP_W'(1);
         end else begin
            cnt_d = dir ? (cnt - ONE) : (cnt + ONE);
         end
      end
      if (!one_shot)
         state_d = RUN;
   end

   // State, count, period latch and wrap counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         p_lat    <= PRST;
         wrap_cnt <= '0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         p_lat    <= p_lat_d;
         wrap_cnt <= wrap_d;
      end
   end

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: scoreboard bench for mode_counter with a
// cycle-level reference model and randomized stimulus.
module tb_mode_counter;

   localparam int CW = 16;
   localparam int WW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en, clr, start, load, dir, one_shot;
   logic [CW-1:0] load_val, period;
   logic [CW-1:0] cnt;
   logic          cnt_end, cnt_mid, busy;
   logic [WW-1:0] wrap_cnt;

   typedef struct {
      logic [CW-1:0] c;
      logic          e;
      logic          m;
      logic          b;
      logic [WW-1:0] w;
   } exp_t;

   exp_t q[$];

   int n_cmp = 0;
   int n_bad = 0;

   logic [CW-1:0] m_cnt;
   logic [CW-1:0] m_p;
   logic [WW-1:0] m_wrap;
   logic          m_run;

   mode_counter #(
      .CNT_W(CW),
      .WRAP_W(WW),
      .PERIOD_RST(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .clr(clr),
      .start(start),
      .load(load),
      .load_val(load_val),
      .period(period),
      .dir(dir),
      .one_shot(one_shot),
      .cnt(cnt),
      .cnt_end(cnt_end),
      .cnt_mid(cnt_mid),
      .busy(busy),
      .wrap_cnt(wrap_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt  = '0;
      m_p    = 16;
      m_wrap = '0;
      m_run  = 1'b0;
   endtask

   // One clock cycle: drive inputs, push expected outputs, advance model
   task automatic cyc(input logic i_en, input logic i_clr,
                      input logic i_start, input logic i_load,
                      input logic [CW-1:0] i_lv, input logic [CW-1:0] i_per,
                      input logic i_dir, input logic i_os);
      exp_t e;
      logic [CW-1:0] pn, pt, tv, sv, mv;
      logic act, st, hit;
      @(negedge clk);
      en = i_en; clr = i_clr; start = i_start; load = i_load;
      load_val = i_lv; period = i_per; dir = i_dir; one_shot = i_os;
      if (!rst_n) begin
         e.c = '0; e.e = 1'b0; e.m = 1'b0; e.b = !i_os; e.w = '0;
         q.push_back(e);
         model_reset();
         return;
      end
      pn  = (i_per == 0) ? 16'd1 : i_per;
      pt  = m_p - 16'd1;
      tv  = i_dir ? 16'd0 : pt;
      sv  = i_dir ? pt : 16'd0;
      mv  = i_dir ? (pt - (m_p / 2)) : (m_p / 2);
      act = m_run || !i_os;
      st  = i_en && act && !i_clr && !i_load;
      hit = st && (m_cnt == tv);
      e.c = m_cnt; e.e = hit; e.m = st && (m_cnt == mv);
      e.b = act; e.w = m_wrap;
      q.push_back(e);
      if (i_clr) begin
         m_cnt = sv; m_p = pn; m_wrap = '0; m_run = 1'b0;
      end else if (i_load) begin
         m_cnt = (i_lv > pt) ? pt : i_lv;
      end else if (i_start && i_os && !m_run) begin
         m_cnt = i_dir ? (pn - 16'd1) : 16'd0;
         m_p = pn; m_run = 1'b1;
      end else if (hit) begin
         m_cnt = sv; m_p = pn; m_run = 1'b0;
         if (m_wrap != 3'd7) m_wrap = m_wrap + 3'd1;
      end else if (st) begin
         m_cnt = i_dir ? (m_cnt - 16'd1) : (m_cnt + 16'd1);
      end
      if (!i_os) m_run = 1'b1;
   endtask

   // Monitor: compare each presented cycle against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("cnt", 32'(cnt), 32'(e.c));
            chk("cnt_end", 32'(cnt_end), 32'(e.e));
            chk("cnt_mid", 32'(cnt_mid), 32'(e.m));
            chk("busy", 32'(busy), 32'(e.b));
            chk("wrap_cnt", 32'(wrap_cnt), 32'(e.w));
         end
      end
   end

   initial begin
      logic r_en, r_clr, r_ld, r_st, r_dir, r_os;
      logic [CW-1:0] r_lv, r_per;
      rst_n = 1'b0;
      en = 0; clr = 0; start = 0; load = 0;
      load_val = '0; period = 16'd5; dir = 0; one_shot = 0;
      model_reset();
      cyc(0, 0, 0, 0, 0, 5, 0, 0);
      cyc(0, 0, 0, 0, 0, 5, 0, 1);
      cyc(0, 0, 0, 0, 0, 5, 0, 1);
      #1 rst_n = 1'b1;

      // up free-run, period 5
      cyc(1, 1, 0, 0, 0, 5, 0, 0);
      for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 5, 0, 0);

      // down one-shot, period 4, restarted twice
      cyc(0, 1, 0, 0, 0, 4, 1, 1);
      cyc(1, 0, 1, 0, 0, 4, 1, 1);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 4, 1, 1);
      cyc(1, 0, 1, 0, 0, 4, 1, 1);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 4, 1, 1);

      // period change 10 -> 3 mid-run
      cyc(1, 1, 0, 0, 0, 10, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 10, 0, 0);
      for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0, 3, 0, 0);

      // load clip and clr/load priority with period 8
      cyc(1, 1, 0, 0, 0, 8, 0, 0);
      cyc(1, 0, 0, 0, 0, 8, 0, 0);
      cyc(1, 0, 0, 1, 20, 8, 0, 0);
      cyc(1, 0, 0, 0, 0, 8, 0, 0);
      cyc(1, 0, 0, 0, 0, 8, 0, 0);
      cyc(1, 1, 0, 1, 5, 8, 0, 0);
      cyc(1, 0, 0, 0, 0, 8, 0, 0);

      // period 0 and 1, wrap saturation
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 1, 1, 0);

      // randomized traffic
      r_per = 6; r_dir = 0; r_os = 0;
      for (int i = 0; i < 3000; i++) begin
         r_en  = ($urandom_range(0, 9) != 0);
         r_clr = ($urandom_range(0, 29) == 0);
         r_ld  = ($urandom_range(0, 14) == 0);
         r_st  = ($urandom_range(0, 3) == 0);
         r_lv  = CW'($urandom_range(0, 20));
         if ($urandom_range(0, 7) == 0) r_per = CW'($urandom_range(0, 12));
         if ($urandom_range(0, 39) == 0) r_dir = !r_dir;
         if ($urandom_range(0, 39) == 0) r_os = !r_os;
         cyc(r_en, r_clr, r_st, r_ld, r_lv, r_per, r_dir, r_os);
      end

      // async reset while counting at cnt=6
      cyc(1, 1, 0, 0, 0, 10, 0, 0);
      for (int i = 0; i < 40; i++) begin
         cyc(1, 0, 0, 0, 0, 10, 0, 0);
         if (i > 12 && m_cnt == 6) break;
      end
      #6;
      chk("pre_rst_cnt", 32'(cnt), 32'd6);
      chk("pre_rst_wrap", 32'(wrap_cnt), 32'(m_wrap));
      #1 rst_n = 1'b0;
      #1;
      chk("arst_cnt", 32'(cnt), 32'd0);
      chk("arst_wrap", 32'(wrap_cnt), 32'd0);
      chk("arst_busy", 32'(busy), 32'd1);
      chk("arst_end", 32'(cnt_end), 32'd0);
      model_reset();
      cyc(1, 0, 0, 0, 0, 10, 0, 1);
      cyc(0, 0, 0, 0, 0, 10, 0, 1);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 10, 0, 0);

      @(negedge clk);
      @(negedge clk);
      #3;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
